aes_inv_key_sched: RTL
======================

AES_INV_KEY_SCHED -- requirements
Module: aes_inv_key_sched

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset; no other clock or reset SHALL exist.
REQ-002 clk  input  1  rising-edge clock; all state SHALL update only on this edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  single-cycle request to begin a walk; sampled only in IDLE.
REQ-005 last_key  input  128  AES-128 round-10 key, word w40 in bits [127:96]; sampled on the accepted start.
REQ-006 out_valid  output  1  round_key and round_idx are valid.
REQ-007 out_ready  input  1  consumer accepts the presented key when high with out_valid.
REQ-008 round_key  output  128  current round key, same word order as last_key.
REQ-009 round_idx  output  4  round number of round_key: 10 down to 0.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse after round 0 is accepted.

Function
REQ-012 FSM states SHALL be IDLE, EMIT, STEP; state SHALL be registered, with registered outputs only.
REQ-013 IDLE: on start=1, next cycle SHALL be EMIT, with round_key=last_key, round_idx=10 and rcon register=0x36.
REQ-014 EMIT: out_valid=1; round_key and round_idx SHALL hold stable while out_ready=0, with no bound on stall length.
REQ-015 EMIT with out_ready=1 and round_idx>0 SHALL go to STEP; with round_idx=0 SHALL go to IDLE and assert done for exactly the next cycle.
REQ-016 STEP: out_valid=0 for exactly one cycle; the previous round key SHALL be registered and the state SHALL return to EMIT with round_idx decremented by 1.
REQ-017 Inverse step for current words (a,b,c,d) = [127:96]..[31:0]: d'=d^c, c'=c^b, b'=b^a, a'=a^SubWord(RotWord(d'))^{rcon,24'h0}.
REQ-018 RotWord SHALL rotate left by one byte; SubWord SHALL apply the forward AES S-box to each byte (four S-box lookups, combinational).
REQ-019 The rcon register SHALL update in STEP by inverse xtime: if bit0=0 then x>>1, else ((x^8'h1b)>>1)|8'h80, producing 36,1b,80,40,20,10,08,04,02,01 for rounds 10..1.
REQ-020 The step for round r SHALL use the rcon of round r (0x36 for 10 to 9, 0x01 for 1 to 0).
REQ-021 A handshake SHALL occur only in EMIT; next key SHALL have out_valid=1 exactly two cycles after the accepting edge.
REQ-022 start SHALL be ignored while busy=1; last_key SHALL be ignored except on the accepted start.
REQ-023 start asserted in the cycle done=1 SHALL be accepted (state is IDLE) and SHALL begin a new walk.
REQ-024 round_idx SHALL never underflow; no STEP SHALL occur from round_idx=0.
REQ-025 Total walk with out_ready tied high: start edge to done pulse SHALL be 1 + 11 EMIT + 10 STEP = 22 cycles.

Reset
REQ-026 rst=1 SHALL force in the next cycle: state=IDLE, out_valid=0, busy=0, done=0, round_key=0, round_idx=0, rcon=0x00.
REQ-027 rst SHALL take priority over start, out_ready and any state, including mid-walk (EMIT or STEP).
REQ-028 After reset deassertion the module SHALL accept start in the first IDLE cycle.

Verification
REQ-029 Start with last_key=d014f9a8c9ee2589e13f0cc8b6630ca6 and out_ready=1 -> round 10 = that key; round 9 = ac7766f319fadc2128d12941575c006e; round 0 = 2b7e151628aed2a6abf7158809cf4f3c; done exactly 22 cycles after start.
REQ-030 Hold out_ready=0 for 5 cycles at round 7 -> round_key and round_idx=7 stable and out_valid=1 throughout; walk then resumes with correct round 6.
REQ-031 Assert start at round 4 -> ignored, and the sequence completes unchanged; start on the done cycle -> new walk begins with round_idx=10.
REQ-032 Assert rst during STEP of round 5 -> next cycle IDLE with all outputs 0; a fresh start then gives correct round 10..0 keys.
REQ-033 Monitor rcon per step -> 36,1b,80,40,20,10,08,04,02,01 in order; randomized out_ready over 1000 random keys -> outputs match a reference forward key expansion reversed.

Source files
------------

// File: rtl/aes_inv_key_sched.sv
// AES-128 inverse key schedule walker: starting from the round-10 key it emits
// round keys 10 down to 0 over a valid/ready handshake, one inverse step per round.
module aes_inv_key_sched (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] last_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    STEP
  } state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  state_t       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   idx_q, idx_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic [31:0]  wa, wb, wc, wd;
  logic [31:0]  na, nb, nc, nd;
  logic [7:0]   rcon_prev;

  // Undo one forward expansion round; d' must be formed first since a' depends on it.
  always_comb begin
    wa = key_q[127:96];
    wb = key_q[95:64];
    wc = key_q[63:32];
    wd = key_q[31:0];
    nd = wd ^ wc;
    nc = wc ^ wb;
    nb = wb ^ wa;
    na = wa ^ sub_word({nd[23:0], nd[31:24]}) ^ {rcon_q, 24'h0};
    rcon_prev = rcon_q[0] ? (((rcon_q ^ 8'h1b) >> 1) | 8'h80) : (rcon_q >> 1);
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    rcon_d  = rcon_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = EMIT;
          key_d   = last_key;
          idx_d   = 4'd10;
          rcon_d  = 8'h36;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      EMIT: begin
        if (out_ready) begin
          valid_d = 1'b0;
          if (idx_q != 4'd0) begin
            state_d = STEP;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      STEP: begin
        key_d   = {na, nb, nc, nd};
        idx_d   = idx_q - 4'd1;
        rcon_d  = rcon_prev;
        state_d = EMIT;
        valid_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      rcon_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      rcon_q  <= rcon_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out_valid = valid_q;
  assign round_key = key_q;
  assign round_idx = idx_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
